traffic_light_controller: RTL and testbench
===========================================

// Module: traffic_light_controller
// PURPOSE
//  Two-way intersection controller: NS main road, EW side road. Holds NS green
//  until its minimum time is up and an EW vehicle waits, then sequences through
//  yellow to EW green and back. Internal timers are a 5-bit NS green timer
//  (32 ticks), a 4-bit EW green timer (16 ticks) and a 2-bit yellow timer
//  (4 ticks). A clock divider gives a 1-tick enable. Drives six lamp outputs directly.
// PARAMETERS
//  NS_GREEN_TICKS  32  minimum NS green time, ticks (5-bit timer)
//  EW_GREEN_TICKS  16  minimum EW green time, ticks (4-bit timer)
//  YELLOW_TICKS     4  yellow time for either direction, ticks (2-bit timer)
//  TICK_DIV         1  clk cycles per tick (1 = every cycle is a tick)
// PORTS
//  clk                in   1  single clock, rising edge
//  rst                in   1  synchronous reset, active-high
//  NS_VEHICLE_DETECT  in   1  vehicle waiting on NS approach (level)
//  EW_VEHICLE_DETECT  in   1  vehicle waiting on EW approach (level)
//  NS_RED/NS_YELLOW/NS_GREEN  out  1 each  NS lamps
//  EW_RED/EW_YELLOW/EW_GREEN  out  1 each  EW lamps
// BEHAVIOUR
//  - States: NSG -> NSY -> EWG -> EWY -> NSG. Lamps decode the state register
//    (Moore), with no extra latency. NSG: NS_GREEN,EW_RED. NSY: NS_YELLOW,EW_RED.
//    EWG: NS_RED,EW_GREEN. EWY: NS_RED,EW_YELLOW.
//  - Reset (rst=1 at posedge): state=NSG, all timers=0, divider=0. Lamps show
//    NS_GREEN=1 and EW_RED=1 in the cycle after reset. Reset mid-sequence
//    overrides everything.
//  - tick=1 when the divider reaches TICK_DIV-1 (divider then wraps to 0). The
//    state and timers update only on tick.
//  - On a tick, the active state's timer t either moves to the next state (t<=0
//    and the next state's timer is cleared) when t==TICKS-1 and the exit
//    condition holds, or does t<=min(t+1,TICKS-1). Timers saturate and never wrap.
//  - Exit conditions:
//    NSG: EW_VEHICLE_DETECT=1.
//    NSY: none (timed).
//    EWG: NS_VEHICLE_DETECT=1 or EW_VEHICLE_DETECT=0.
//    EWY: none (timed).
//  - Detect inputs are sampled on tick edges only. No latching: a pulse that
//    falls before the minimum time expires is lost.
//  - Simultaneous detects at NSG expiry go to NSY. Both detects at EWG expiry
//    go to EWY.
//  - Invariants: exactly one lamp on per direction. NS and EW are never both
//    non-red.
// TESTING (TICK_DIV=1; edge n = nth posedge after rst drops)
//  1 Reset, both detects 0, run 200 cycles -> NS_GREEN=1, EW_RED=1 throughout.
//  2 Both detects 1 from reset -> NSY after edge 32..35, EWG after edge
//    36..51, EWY after edge 52..55, NSG at edge 56. Cycle repeats with period 56.
//  3 Detects 0 until edge 100, then EW=1 -> NSY at edge 101, EWG at edge 105.
//  4 EW=1, NS=0 held -> EWG persists past 16 ticks. Raise NS at edge 80 ->
//    EWY next edge, NSG 4 edges later.
//  5 rst=1 for one edge during EWG -> next cycle NS_GREEN=1, EW_RED=1. The
//    NSG minimum restarts from 0.
//  6 Random detect stimulus, 5000 cycles -> assert the lamp invariants every cycle.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Two-way intersection controller: NS main road held green until EW demand,
// sequenced NSG -> NSY -> EWG -> EWY with saturating per-phase timers.
module traffic_light_controller #(
  parameter int NS_GREEN_TICKS = 32,
  parameter int EW_GREEN_TICKS = 16,
  parameter int YELLOW_TICKS   = 4,
  parameter int TICK_DIV       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic NS_VEHICLE_DETECT,
  input  logic EW_VEHICLE_DETECT,
  output logic NS_RED,
  output logic NS_YELLOW,
  output logic NS_GREEN,
  output logic EW_RED,
  output logic EW_YELLOW,
  output logic EW_GREEN
);

  localparam int NS_W  = (NS_GREEN_TICKS > 1) ? $clog2(NS_GREEN_TICKS) : 1;
  localparam int EW_W  = (EW_GREEN_TICKS > 1) ? $clog2(EW_GREEN_TICKS) : 1;
  localparam int Y_W   = (YELLOW_TICKS   > 1) ? $clog2(YELLOW_TICKS)   : 1;
  localparam int DIV_W = (TICK_DIV       > 1) ? $clog2(TICK_DIV)       : 1;

  localparam logic [NS_W-1:0]  NS_LAST  = NS_W'(NS_GREEN_TICKS - 1);
  localparam logic [EW_W-1:0]  EW_LAST  = EW_W'(EW_GREEN_TICKS - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(YELLOW_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {NSG, NSY, EWG, EWY} state_t;

  state_t           state;
  logic [NS_W-1:0]  ns_t;
  logic [EW_W-1:0]  ew_t;
  logic [Y_W-1:0]   y_t;
  logic [DIV_W-1:0] div;
  logic [5:0]       lamps;
  logic             tick;

  // Lamp vector order: {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}
  function automatic logic [5:0] lamp_of(input state_t s);
    case (s)
      NSG:     lamp_of = 6'b001_100;
      NSY:     lamp_of = 6'b010_100;
      EWG:     lamp_of = 6'b100_001;
      EWY:     lamp_of = 6'b100_010;
      default: lamp_of = 6'b100_100;
    endcase
  endfunction

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Lamps are loaded alongside each state change so they track the state
  // register with no added latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NSG;
      ns_t  <= '0;
      ew_t  <= '0;
      y_t   <= '0;
      lamps <= lamp_of(NSG);
    end else if (tick) begin
      case (state)
        NSG: begin
          if (ns_t == NS_LAST && EW_VEHICLE_DETECT) begin
            state <= NSY;
            ns_t  <= '0;
            y_t   <= '0;
            lamps <= lamp_of(NSY);
          end else if (ns_t != NS_LAST) begin
            ns_t <= ns_t + 1'b1;
          end
        end
        NSY: begin
          if (y_t == Y_LAST) begin
            state <= EWG;
            y_t   <= '0;
            ew_t  <= '0;
            lamps <= lamp_of(EWG);
          end else begin
            y_t <= y_t + 1'b1;
          end
        end
        EWG: begin
          if (ew_t == EW_LAST && (NS_VEHICLE_DETECT || !EW_VEHICLE_DETECT)) begin
            state <= EWY;
            ew_t  <= '0;
            y_t   <= '0;
            lamps <= lamp_of(EWY);
          end else if (ew_t != EW_LAST) begin
            ew_t <= ew_t + 1'b1;
          end
        end
        EWY: begin
          if (y_t == Y_LAST) begin
            state <= NSG;
            y_t   <= '0;
            ns_t  <= '0;
            lamps <= lamp_of(NSG);
          end else begin
            y_t <= y_t + 1'b1;
          end
        end
        default: begin
          state <= NSG;
          lamps <= lamp_of(NSG);
        end
      endcase
    end
  end

  assign {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN} = lamps;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed scenarios plus random detects,
// compared each cycle against a phase/elapsed-ticks model.
module tb_traffic_light_controller;

  localparam logic [5:0] P_NSG = 6'b001100;
  localparam logic [5:0] P_NSY = 6'b010100;
  localparam logic [5:0] P_EWG = 6'b100001;
  localparam logic [5:0] P_EWY = 6'b100010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ns_det = 1'b0;
  logic ew_det = 1'b0;
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;

  int checks = 0;
  int errors = 0;
  int e = 0;
  int ph = 0;
  int cnt = 0;
  logic [5:0] obs;

  int         dur[4]      = '{32, 4, 16, 4};
  logic [5:0] lamp_tab[4] = '{P_NSG, P_NSY, P_EWG, P_EWY};

  traffic_light_controller dut (
    .clk(clk), .rst(rst),
    .NS_VEHICLE_DETECT(ns_det), .EW_VEHICLE_DETECT(ew_det),
    .NS_RED(ns_r), .NS_YELLOW(ns_y), .NS_GREEN(ns_g),
    .EW_RED(ew_r), .EW_YELLOW(ew_y), .EW_GREEN(ew_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, e, got, exp);
    end
  endtask

  function automatic bit leave(input int p, input logic nsd, input logic ewd);
    case (p)
      0:       return ewd;
      2:       return nsd || !ewd;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic cyc(input logic r, input logic nsd, input logic ewd);
    @(negedge clk);
    rst = r; ns_det = nsd; ew_det = ewd;
    @(posedge clk);
    if (r) begin
      ph = 0; cnt = 0; e = 0;
    end else begin
      e++;
      if (cnt >= dur[ph] - 1 && leave(ph, nsd, ewd)) begin
        ph = (ph + 1) % 4; cnt = 0;
      end else begin
        cnt++;
      end
    end
    #1;
    obs = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};
    check("model", obs, lamp_tab[ph]);
    check("inv", {3'b000, $countones(obs[5:3]) == 1, $countones(obs[2:0]) == 1,
                  obs[5] || obs[2]}, 6'b000111);
  endtask

  initial begin
    // 1: idle, no demand
    cyc(1, 0, 0);
    check("t1_reset", obs, P_NSG);
    repeat (200) cyc(0, 0, 0);
    check("t1_idle", obs, P_NSG);

    // 2: both detects held, full cycle twice
    cyc(1, 1, 1);
    for (int i = 0; i < 112; i++) begin
      cyc(0, 1, 1);
      if (e == 31)  check("t2_e31", obs, P_NSG);
      if (e == 32)  check("t2_e32", obs, P_NSY);
      if (e == 35)  check("t2_e35", obs, P_NSY);
      if (e == 36)  check("t2_e36", obs, P_EWG);
      if (e == 51)  check("t2_e51", obs, P_EWG);
      if (e == 52)  check("t2_e52", obs, P_EWY);
      if (e == 56)  check("t2_e56", obs, P_NSG);
      if (e == 88)  check("t2_e88", obs, P_NSY);
      if (e == 112) check("t2_e112", obs, P_NSG);
    end

    // 3: late EW demand against a saturated NS timer
    cyc(1, 0, 0);
    for (int i = 0; i < 110; i++) begin
      if (e < 100) cyc(0, 0, 0);
      else         cyc(0, 0, 1);
      if (e == 100) check("t3_e100", obs, P_NSG);
      if (e == 101) check("t3_e101", obs, P_NSY);
      if (e == 104) check("t3_e104", obs, P_NSY);
      if (e == 105) check("t3_e105", obs, P_EWG);
    end

    // 4: EW held without NS demand, then NS arrives
    cyc(1, 0, 1);
    for (int i = 0; i < 90; i++) begin
      if (e < 80) cyc(0, 0, 1);
      else        cyc(0, 1, 1);
      if (e == 60) check("t4_e60", obs, P_EWG);
      if (e == 80) check("t4_e80", obs, P_EWG);
      if (e == 81) check("t4_e81", obs, P_EWY);
      if (e == 84) check("t4_e84", obs, P_EWY);
      if (e == 85) check("t4_e85", obs, P_NSG);
    end

    // 5: reset during EWG restarts the NS minimum
    cyc(1, 0, 1);
    while (e < 40) cyc(0, 0, 1);
    check("t5_pre", obs, P_EWG);
    cyc(1, 0, 1);
    check("t5_rst", obs, P_NSG);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 1);
      if (e == 31) check("t5_e31", obs, P_NSG);
      if (e == 32) check("t5_e32", obs, P_NSY);
    end

    // 6: random demand with rare resets
    cyc(1, 0, 0);
    for (int i = 0; i < 5000; i++)
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
